// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path:
// opcodes, FSM states and datapath mux selects.
package rv_ctrl_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [2:0] {
        ST_FETCH  = 3'd0,
        ST_DECODE = 3'd1,
        ST_EXEC   = 3'd2,
        ST_MEM    = 3'd3,
        ST_WB     = 3'd4,
        ST_TRAP   = 3'd7
    } state_t;

    localparam logic [1:0] PC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_BRANCH = 2'd1;
    localparam logic [1:0] PC_JALR   = 2'd2;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] SRC_A_RS1  = 2'd0;
    localparam logic [1:0] SRC_A_PC   = 2'd1;
    localparam logic [1:0] SRC_A_ZERO = 2'd2;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_BR  = 2'd1;
    localparam logic [1:0] ALU_R   = 2'd2;
    localparam logic [1:0] ALU_I   = 2'd3;

    function automatic logic opc_supported(input logic [6:0] opc);
        return opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
                           OPC_BRANCH, OPC_LOAD, OPC_STORE,
                           OPC_OP_IMM, OPC_OP, OPC_FENCE};
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Saturating wait counter for memory handshakes; flags the
// last permitted wait cycle so the FSM can trap.
module mem_wait_timer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMR_W       = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic inc,
    output logic timeout
);

    localparam int unsigned LIM = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
    localparam logic [TMR_W-1:0] LIMIT = TMR_W'(LIM);

    logic [TMR_W-1:0] cnt_q;
    logic [TMR_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign timeout = (MEM_TIMEOUT != 0) && (cnt_q == LIMIT);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXEC/MEM/WB
// and drives the shared datapath strobes.
module multicycle_ctrl
    import rv_ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned TMR_W       = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        imem_ready,
    input  logic        dmem_ready,
    output logic        imem_req,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic        ir_we,
    output logic        pc_we,
    output logic [1:0]  pc_sel,
    output logic [1:0]  alu_src_a,
    output logic        alu_src_b,
    output logic [1:0]  alu_op,
    output logic        reg_we,
    output logic [1:0]  wb_sel,
    output logic        retired,
    output logic        illegal,
    output logic        mem_err,
    output logic [2:0]  state
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_err_q, mem_err_d;
    logic   tmo;
    logic   tmr_inc;
    logic   unused_instr;
    logic [6:0] opc;
    logic [1:0] dec_a;
    logic       dec_b;
    logic [1:0] dec_op;

    assign opc          = instr[6:0];
    assign unused_instr = ^instr[31:7];

    assign tmr_inc = ((state_q == ST_FETCH) && !imem_ready) ||
                     ((state_q == ST_MEM) && !dmem_ready);

    mem_wait_timer #(
        .MEM_TIMEOUT(MEM_TIMEOUT),
        .TMR_W      (TMR_W)
    ) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .clear  (state_d != state_q),
        .inc    (tmr_inc),
        .timeout(tmo)
    );

    always_comb begin
        dec_a  = SRC_A_RS1;
        dec_b  = 1'b0;
        dec_op = ALU_ADD;
        unique case (1'b1)
            opc == OPC_OP:     dec_op = ALU_R;
            opc == OPC_OP_IMM: begin dec_b = 1'b1; dec_op = ALU_I; end
            opc == OPC_LUI:    begin dec_a = SRC_A_ZERO; dec_b = 1'b1; end
            opc == OPC_AUIPC:  begin dec_a = SRC_A_PC; dec_b = 1'b1; end
            opc == OPC_LOAD,
            opc == OPC_STORE,
            opc == OPC_JALR:   dec_b = 1'b1;
            opc == OPC_BRANCH: dec_op = ALU_BR;
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        illegal_d = illegal_q;
        mem_err_d = mem_err_q;
        imem_req  = 1'b0;
        dmem_req  = 1'b0;
        dmem_we   = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_sel    = PC_PLUS4;
        alu_src_a = SRC_A_RS1;
        alu_src_b = 1'b0;
        alu_op    = ALU_ADD;
        reg_we    = 1'b0;
        wb_sel    = WB_ALU;
        retired   = 1'b0;

        // ALU selects stay stable from EXEC until the instruction retires
        if (state_q inside {ST_EXEC, ST_MEM, ST_WB}) begin
            alu_src_a = dec_a;
            alu_src_b = dec_b;
            alu_op    = dec_op;
        end

        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                if (imem_ready) begin
                    ir_we   = 1'b1;
                    state_d = ST_DECODE;
                end else if (tmo) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_DECODE: begin
                if (opc_supported(opc)) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                unique case (1'b1)
                    opc == OPC_BRANCH: begin
                        pc_we   = 1'b1;
                        pc_sel  = branch_taken ? PC_BRANCH : PC_PLUS4;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end
                    opc == OPC_JAL,
                    opc == OPC_JALR: begin
                        pc_we   = 1'b1;
                        pc_sel  = (opc == OPC_JAL) ? PC_BRANCH : PC_JALR;
                        reg_we  = 1'b1;
                        wb_sel  = WB_PC4;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end
                    opc == OPC_FENCE: begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end
                    opc == OPC_LOAD,
                    opc == OPC_STORE: state_d = ST_MEM;
                    default:          state_d = ST_WB;
                endcase
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = (opc == OPC_STORE);
                if (dmem_ready) begin
                    if (opc == OPC_STORE) begin
                        pc_we   = 1'b1;
                        retired = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (tmo) begin
                    mem_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_WB: begin
                reg_we  = 1'b1;
                wb_sel  = (opc == OPC_LOAD) ? WB_LOAD : WB_ALU;
                pc_we   = 1'b1;
                retired = 1'b1;
                state_d = ST_FETCH;
            end
            ST_TRAP: ;
            default: state_d = ST_TRAP;
        endcase

        // Reset silences every strobe at once, even mid-handshake
        if (!rst_n) begin
            imem_req  = 1'b0;
            dmem_req  = 1'b0;
            dmem_we   = 1'b0;
            ir_we     = 1'b0;
            pc_we     = 1'b0;
            pc_sel    = PC_PLUS4;
            alu_src_a = SRC_A_RS1;
            alu_src_b = 1'b0;
            alu_op    = ALU_ADD;
            reg_we    = 1'b0;
            wb_sel    = WB_ALU;
            retired   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FETCH;
            illegal_q <= 1'b0;
            mem_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
            mem_err_q <= mem_err_d;
        end
    end

    assign illegal = illegal_q;
    assign mem_err = mem_err_q;
    assign state   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: driver queues expected
// retirements, a monitor checks each retire pulse.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] instr = '0;
    logic        branch_taken = 1'b0;
    logic        imem_ready = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        imem_req, dmem_req, dmem_we, ir_we, pc_we;
    logic [1:0]  pc_sel, alu_src_a, alu_op, wb_sel;
    logic        alu_src_b, reg_we, retired, illegal, mem_err;
    logic [2:0]  state;

    always #5 clk = ~clk;

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TMR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .instr(instr),
        .branch_taken(branch_taken),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .imem_req(imem_req), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .reg_we(reg_we), .wb_sel(wb_sel), .retired(retired),
        .illegal(illegal), .mem_err(mem_err), .state(state)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef enum {K_OP, K_OPI, K_LUI, K_AUIPC, K_LD,
                  K_ST, K_BR, K_JAL, K_JALR, K_FENCE} kind_t;

    typedef struct packed {
        int       when;
        bit       st;
        bit [1:0] pc_sel;
        bit       reg_we;
        bit       chk_wb;
        bit [1:0] wb_sel;
        bit       chk_ab;
        bit [1:0] a;
        bit       b;
        bit       chk_op;
        bit [1:0] op;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [6:0] opc_of(input kind_t k);
        case (k)
            K_OP:    return 7'b0110011;
            K_OPI:   return 7'b0010011;
            K_LUI:   return 7'b0110111;
            K_AUIPC: return 7'b0010111;
            K_LD:    return 7'b0000011;
            K_ST:    return 7'b0100011;
            K_BR:    return 7'b1100011;
            K_JAL:   return 7'b1101111;
            K_JALR:  return 7'b1100111;
            default: return 7'b0001111;
        endcase
    endfunction

    function automatic logic [31:0] word_of(input kind_t k);
        logic [31:0] r;
        r = $urandom();
        return {r[31:7], opc_of(k)};
    endfunction

    // Expected retirement: latency from the phase list, controls from the ISA table
    function automatic exp_t model(input kind_t k, input bit bt,
                                   input int fw, input int mw, input int start);
        exp_t e;
        bit   has_mem, has_wb;
        e = '0;
        has_mem = (k == K_LD) || (k == K_ST);
        has_wb  = (k inside {K_OP, K_OPI, K_LUI, K_AUIPC, K_LD});
        e.when = start + (fw + 1) + 2 + (has_mem ? mw + 1 : 0) + (has_wb ? 1 : 0) - 1;
        e.st = (k == K_ST);
        case (k)
            K_OP:    begin e.reg_we = 1; e.chk_wb = 1; e.chk_ab = 1; e.chk_op = 1;
                           e.a = 0; e.b = 0; e.op = 2; end
            K_OPI:   begin e.reg_we = 1; e.chk_wb = 1; e.chk_ab = 1; e.chk_op = 1;
                           e.a = 0; e.b = 1; e.op = 3; end
            K_LUI:   begin e.reg_we = 1; e.chk_wb = 1; e.chk_ab = 1; e.chk_op = 1;
                           e.a = 2; e.b = 1; e.op = 0; end
            K_AUIPC: begin e.reg_we = 1; e.chk_wb = 1; e.chk_ab = 1; e.chk_op = 1;
                           e.a = 1; e.b = 1; e.op = 0; end
            K_LD:    begin e.reg_we = 1; e.chk_wb = 1; e.wb_sel = 1; e.chk_ab = 1;
                           e.chk_op = 1; e.a = 0; e.b = 1; e.op = 0; end
            K_ST:    begin e.chk_ab = 1; e.chk_op = 1; e.a = 0; e.b = 1; e.op = 0; end
            K_BR:    begin e.pc_sel = bt ? 2'd1 : 2'd0; e.chk_op = 1; e.op = 1; end
            K_JAL:   begin e.pc_sel = 1; e.reg_we = 1; e.chk_wb = 1; e.wb_sel = 2; end
            K_JALR:  begin e.pc_sel = 2; e.reg_we = 1; e.chk_wb = 1; e.wb_sel = 2;
                           e.chk_ab = 1; e.chk_op = 1; e.a = 0; e.b = 1; e.op = 0; end
            default: ;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (dmem_req && q.size() > 0) check("dmem_we", dmem_we, q[0].st);
            if (retired) begin
                if (q.size() == 0) begin
                    check("spurious_retire", 1, 0);
                end else begin
                    mon_e = q.pop_front();
                    check("retire_cycle", cyc, mon_e.when);
                    check("pc_we", pc_we, 1);
                    check("pc_sel", pc_sel, mon_e.pc_sel);
                    check("reg_we", reg_we, mon_e.reg_we);
                    check("ret_dmem_req", dmem_req, mon_e.st);
                    if (mon_e.chk_wb) check("wb_sel", wb_sel, mon_e.wb_sel);
                    if (mon_e.chk_ab) begin
                        check("alu_src_a", alu_src_a, mon_e.a);
                        check("alu_src_b", alu_src_b, mon_e.b);
                    end
                    if (mon_e.chk_op) check("alu_op", alu_op, mon_e.op);
                end
            end
        end
    end

    task automatic run_instr(input kind_t k, input logic [31:0] word,
                             input bit bt, input int fw, input int mw);
        bit done;
        int mcnt;
        q.push_back(model(k, bt, fw, mw, cyc));
        instr = word;
        branch_taken = bt;
        for (int i = 0; i <= fw; i++) begin
            imem_ready = (i == fw);
            if (i == fw) begin
                #1;
                check("ir_we", ir_we, 1);
            end
            @(negedge clk);
        end
        imem_ready = 1'b0;
        done = 1'b0;
        mcnt = 0;
        for (int t = 0; t < 30 && !done; t++) begin
            dmem_ready = dmem_req && (mcnt == mw);
            if (dmem_req) mcnt++;
            #1;
            done = retired;
            @(negedge clk);
        end
        dmem_ready = 1'b0;
        if (!done) check("retire_timeout", 0, 1);
    endtask

    initial begin
        int n;
        kind_t k;
        repeat (2) @(negedge clk);
        #1;
        check("rst_state", state, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_illegal", illegal, 0);
        check("rst_mem_err", mem_err, 0);
        rst_n = 1'b1;
        #1;
        check("post_rst_imem_req", imem_req, 1);

        run_instr(K_OPI, 32'h00500093, 1'b0, 0, 0);
        run_instr(K_LD, 32'h0000A103, 1'b0, 0, 3);
        run_instr(K_BR, 32'h00000463, 1'b1, 0, 0);
        run_instr(K_BR, 32'h00000463, 1'b0, 0, 0);

        instr = 32'h0;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        #1 check("ill_decode", state, 1);
        @(negedge clk);
        #1 check("ill_trap", state, 7);
        check("ill_flag", illegal, 1);
        n = 0;
        repeat (20) begin
            @(negedge clk);
            #1;
            if (imem_req) n++;
        end
        check("trap_no_req", n, 0);
        rst_n = 1'b0;
        #1 check("ill_cleared", illegal, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("ill_resume", imem_req, 1);

        n = 0;
        for (int t = 0; t < 20; t++) begin
            if (state == 3'd7) break;
            if (imem_req) n++;
            @(negedge clk);
            #1;
        end
        check("tmo_req_cycles", n, 4);
        check("tmo_state", state, 7);
        check("tmo_mem_err", mem_err, 1);
        rst_n = 1'b0;
        #1 check("tmo_cleared", mem_err, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        run_instr(K_OPI, 32'h00500093, 1'b0, 3, 0);
        check("edge_no_trap", mem_err, 0);

        instr = 32'h0020A023;
        imem_ready = 1'b1;
        @(negedge clk);
        imem_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("sw_req", dmem_req, 1);
        check("sw_we", dmem_we, 1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("sw_async_drop", dmem_req, 0);
        check("sw_rst_state", state, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("sw_resume_state", state, 0);
        check("sw_resume_req", imem_req, 1);

        for (int i = 0; i < 150; i++) begin
            k = kind_t'($urandom_range(0, 9));
            run_instr(k, word_of(k), 1'($urandom_range(0, 1)),
                      $urandom_range(0, 3), $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        check("queue_empty", q.size(), 0);
        check("end_illegal", illegal, 0);
        check("end_mem_err", mem_err, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
